// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM port status, data word and the RAM arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requesting index at or after rr_ptr, modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   rr_ptr,
  output logic            valid,
  output logic [OW-1:0]   winner
);

  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!valid && req[OW'(idx)]) begin
        valid  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters.
// Define RAM_ARB_AGING_EN to add per-requester starvation aging that overrides the rotation.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AGE_MAX = 15,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wen,
  input  logic [NREQ-1:0][31:0] addr,
  input  logic [NREQ-1:0][31:0] store,
  output logic [NREQ-1:0]       rwait,
  output word_t                 load,
  input  ramstate_t             ramstate,
  input  word_t                 ramload,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  // Handshake: a requester holds req (with wen/addr/store stable) until its
  // rwait bit drops; rwait[i] is low only in the cycle RAM reports ACCESS for
  // the current owner, and that cycle completes the transfer.

  arb_state_t    state;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] next_ptr;
  logic [OW-1:0] pick_idx;
  logic [OW-1:0] win_idx;
  logic          pick_valid;
  logic          access;

  assign access   = (ramstate == ACCESS);
  assign next_ptr = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign busy     = (state == GRANT);
  assign load     = ramload;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

`ifdef RAM_ARB_AGING_EN
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [AW-1:0] AGE_TOP = AW'(AGE_MAX);

  logic [AW-1:0] age [NREQ];
  logic          aged_hit;
  logic [OW-1:0] aged_idx;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREQ; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (busy && access && owner == OW'(i))
          age[i] <= '0;
        else if (req[i] && !(busy && owner == OW'(i)) && age[i] != AGE_TOP)
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Descending scan so the lowest starved index is the one left standing.
  always_comb begin
    aged_hit = 1'b0;
    aged_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && age[i] == AGE_TOP) begin
        aged_hit = 1'b1;
        aged_idx = OW'(i);
      end
    end
  end

  assign win_idx = aged_hit ? aged_idx : pick_idx;
`else
  logic unused_age_max;
  assign unused_age_max = (AGE_MAX != 0);
  assign win_idx        = pick_idx;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= win_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (access) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (!req[owner]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A dropped request releases the RAM strobes in the same cycle.
  always_comb begin
    rwait    = '1;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    if (state == GRANT) begin
      rwait[owner] = !access;
      if (req[owner]) begin
        ramaddr  = addr[owner];
        ramstore = store[owner];
        ramWEN   = wen[owner];
        ramREN   = !wen[owner];
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests, a latency-programmable RAM model,
// and a negedge monitor that checks every completed transfer against an expected queue.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ  = 4;
  localparam int TXN_W = 72;
`ifdef RAM_ARB_AGING_EN
  localparam int TB_AGE_MAX = 3;
`else
  localparam int TB_AGE_MAX = 15;
`endif

  logic                  CLK = 1'b0;
  logic                  nRST = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       wen = '0;
  logic [NREQ-1:0][31:0] addr = '0;
  logic [NREQ-1:0][31:0] store = '0;
  logic [NREQ-1:0]       rwait;
  word_t                 load;
  ramstate_t             ramstate = FREE;
  word_t                 ramload = '0;
  word_t                 ramaddr;
  word_t                 ramstore;
  logic                  ramREN;
  logic                  ramWEN;
  logic [1:0]            owner;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ram_lat = 0;
  int err_left = 0;
  int ram_cnt = 0;

  logic [TXN_W-1:0] exp_q[$];
  logic [TXN_W-1:0] obs;
  logic [TXN_W-1:0] exp_txn;
  logic [9:0]       busy_tr;

  ram_arbiter #(.NREQ(NREQ), .AGE_MAX(TB_AGE_MAX)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .req      (req),
    .wen      (wen),
    .addr     (addr),
    .store    (store),
    .rwait    (rwait),
    .load     (load),
    .ramstate (ramstate),
    .ramload  (ramload),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .owner    (owner),
    .busy     (busy)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  // RAM model: ERROR for err_left cycles, then BUSY for ram_lat cycles, then one ACCESS.
  always @(posedge CLK) begin
    #2;
    if (!nRST) begin
      ramstate = FREE;
      ram_cnt  = 0;
    end else if (ramREN || ramWEN) begin
      if (err_left > 0) begin
        ramstate = ERROR;
        err_left = err_left - 1;
      end else if (ram_cnt >= ram_lat) begin
        ramstate = ACCESS;
        ramload  = ramaddr ^ 32'hA5A5_0000;
        ram_cnt  = 0;
      end else begin
        ramstate = BUSY;
        ram_cnt  = ram_cnt + 1;
      end
    end else begin
      ramstate = FREE;
      ram_cnt  = 0;
    end
  end

  task automatic check(input string name, input logic [TXN_W-1:0] act, input logic [TXN_W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TXN_W-1:0] mk_txn(input logic [1:0] own, input logic w,
                                              input logic [31:0] a, input logic [31:0] d,
                                              input logic [3:0] rw);
    return {own, w, ~w, a, d, rw};
  endfunction

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (nRST) begin
      if (!busy || ramstate != ACCESS) check("rwait_hold", TXN_W'(rwait), TXN_W'(4'hF));
      if (!busy) check("idle_strobes", TXN_W'({ramREN, ramWEN}), '0);
      if (busy && ramstate == ACCESS) begin
        obs = {owner, ramWEN, ramREN, ramaddr, (ramWEN ? ramstore : load), rwait};
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_txn: got %0h expected none", obs);
        end else begin
          exp_txn = exp_q.pop_front();
          check("txn", obs, exp_txn);
        end
        done_cnt = done_cnt + 1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input string name, input int max);
    int  start;
    bit  seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge CLK);
      #1;
      if (done_cnt != start) seen = 1'b1;
    end
    checks = checks + 1;
    if (!seen) begin
      errors = errors + 1;
      $display("FAIL %s: got no completion expected one within %0d cycles", name, max);
    end
  endtask

  task automatic do_reset();
    req      = '0;
    wen      = '0;
    addr     = '0;
    store    = '0;
    err_left = 0;
    nRST     = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    // reset state
    @(negedge CLK);
    check("reset_busy", TXN_W'(busy), '0);
    check("reset_owner", TXN_W'(owner), '0);
    check("reset_strobes", TXN_W'({ramREN, ramWEN}), '0);
    check("reset_addr_store", TXN_W'({ramaddr, ramstore}), '0);
    check("reset_rwait", TXN_W'(rwait), TXN_W'(4'hF));
    do_reset();

    // single read, then rr_ptr=3 shows up as requester 3 winning a full request set
    ram_lat = 1;
    req[2]  = 1'b1;
    addr[2] = 32'h40;
    exp_q.push_back(mk_txn(2'd2, 1'b0, 32'h40, 32'hA5A5_0040, 4'b1011));
    tick();
    @(negedge CLK);
    check("read_strobes", TXN_W'({ramREN, ramWEN, ramaddr, rwait}), TXN_W'({1'b1, 1'b0, 32'h40, 4'hF}));
    wait_done("read_done", 2);
    check("read_rwait_access", TXN_W'(rwait), TXN_W'(4'b1011));
    tick();
    ram_lat = 0;
    req     = 4'b1111;
    for (int i = 0; i < NREQ; i++) addr[i] = 32'h100 + 32'(4 * i);
    exp_q.push_back(mk_txn(2'd3, 1'b0, 32'h10C, 32'hA5A5_010C, 4'b0111));
    wait_done("rr_after_read", 4);
    tick();
    req = '0;
    tick();

    // rotation with a 1-cycle RAM
    do_reset();
    ram_lat = 0;
    req     = 4'b1111;
    for (int i = 0; i < NREQ; i++) addr[i] = 32'h100 + 32'(4 * i);
    for (int i = 0; i < 5; i++)
      exp_q.push_back(mk_txn(2'(i % 4), 1'b0, 32'h100 + 32'(4 * (i % 4)),
                             32'hA5A5_0100 + 32'(4 * (i % 4)), ~(4'b0001 << (i % 4))));
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      busy_tr[c] = busy;
      tick();
    end
    req = '0;
    check("rotation_gaps", TXN_W'(busy_tr), TXN_W'(10'b10_1010_1010));
    tick();
    tick();
    check("rotation_drained", TXN_W'(exp_q.size()), '0);

    // write path
    do_reset();
    ram_lat  = 1;
    req[1]   = 1'b1;
    wen[1]   = 1'b1;
    addr[1]  = 32'h80;
    store[1] = 32'hDEAD_BEEF;
    exp_q.push_back(mk_txn(2'd1, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'b1101));
    tick();
    @(negedge CLK);
    check("write_strobes", TXN_W'({ramREN, ramWEN, ramstore, ramaddr, rwait}),
          TXN_W'({1'b0, 1'b1, 32'hDEAD_BEEF, 32'h80, 4'hF}));
    wait_done("write_done", 3);
    check("write_rwait_access", TXN_W'(rwait), TXN_W'(4'b1101));
    tick();
    req = '0;
    wen = '0;
    tick();

    // abort by requester 1; rr_ptr stays 0 so requester 1 beats 2 afterwards
    do_reset();
    ram_lat = 3;
    req[1]  = 1'b1;
    addr[1] = 32'h24;
    tick();
    tick();
    req[1] = 1'b0;
    @(negedge CLK);
    check("abort_same_cycle", TXN_W'({busy, ramREN, ramWEN, rwait}), TXN_W'({1'b1, 1'b0, 1'b0, 4'hF}));
    tick();
    @(negedge CLK);
    check("abort_idle", TXN_W'(busy), '0);
    ram_lat = 0;
    req     = 4'b0110;
    addr[1] = 32'h104;
    addr[2] = 32'h108;
    exp_q.push_back(mk_txn(2'd1, 1'b0, 32'h104, 32'hA5A5_0104, 4'b1101));
    wait_done("abort_rr_keep", 4);
    tick();
    req = '0;
    tick();

    // reset asserted mid-grant
    ram_lat = 3;
    req[3]  = 1'b1;
    addr[3] = 32'h3C;
    tick();
    tick();
    @(negedge CLK);
    check("pre_reset_grant", TXN_W'({busy, owner, ramREN}), TXN_W'({1'b1, 2'd3, 1'b1}));
    #1;
    nRST = 1'b0;
    #1;
    check("midgrant_reset", TXN_W'({busy, owner, ramREN, ramWEN, ramaddr, rwait}),
          TXN_W'({1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'hF}));
    req = '0;
    tick();
    nRST = 1'b1;
    tick();

    // ERROR held for 10 cycles, completion on first ACCESS
    do_reset();
    ram_lat  = 0;
    err_left = 10;
    req[0]   = 1'b1;
    addr[0]  = 32'h10;
    exp_q.push_back(mk_txn(2'd0, 1'b0, 32'h10, 32'hA5A5_0010, 4'b1110));
    for (int k = 1; k <= 10; k++) begin
      tick();
      @(negedge CLK);
      check("error_hold", TXN_W'({busy, owner, ramREN, rwait, (ramstate == ERROR)}),
            TXN_W'({1'b1, 2'd0, 1'b1, 4'hF, 1'b1}));
    end
    wait_done("error_first_access", 1);
    tick();
    req = '0;
    tick();

`ifdef RAM_ARB_AGING_EN
    // starvation: requester 3 overrides rr_ptr=1 although requester 1 is also waiting
    do_reset();
    ram_lat = 5;
    req     = 4'b1001;
    addr[0] = 32'h0;
    addr[3] = 32'h30;
    exp_q.push_back(mk_txn(2'd0, 1'b0, 32'h0, 32'hA5A5_0000, 4'b1110));
    wait_done("starve_first", 10);
    req[1]  = 1'b1;
    addr[1] = 32'h14;
    exp_q.push_back(mk_txn(2'd3, 1'b0, 32'h30, 32'hA5A5_0030, 4'b0111));
    wait_done("starve_override", 12);
    tick();
    req = '0;
    tick();
`endif

    // final report
    tick();
    tick();
    check("queue_empty", TXN_W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
